// File: rtl/store_trace_fifo.sv
// store_trace_fifo: captures processor stores that hit an address window into a
// FIFO for a trace consumer, counting stores dropped while full.
module store_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int DROPW = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       memwrite,
  input  logic [31:0]                pc,
  input  logic [31:0]                dataadr,
  input  logic [31:0]                writedata,
  input  logic [31:0]                win_base,
  input  logic [31:0]                win_mask,
  input  logic                       clear,
  input  logic                       trace_ready,
  output logic                       trace_valid,
  output logic [31:0]                trace_pc,
  output logic [31:0]                trace_adr,
  output logic [31:0]                trace_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [DROPW-1:0]           drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [95:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [DROPW-1:0] drop_cnt_q, drop_cnt_d;
  logic             qual, pop, push, drop;
  always_comb begin
    qual       = memwrite && ((dataadr & win_mask) == win_base);
    pop        = (count_q != '0) && trace_ready;
    push       = qual && ((count_q != FULL) || pop);
    drop       = qual && !push;
    wr_ptr_d   = clear ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d   = clear ? '0 : rd_ptr_q + AW'(pop);
    count_d    = clear ? '0 : count_q + CW'(push) - CW'(pop);
    overflow_d = !clear && (overflow_q || drop);
    drop_cnt_d = clear ? '0 : (drop && drop_cnt_q != '1) ? drop_cnt_q + 1'b1 : drop_cnt_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  // Storage is left unreset; every read is masked by trace_valid.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= {pc, dataadr, writedata};
  end
  always_comb begin
    trace_valid                        = count_q != '0;
    {trace_pc, trace_adr, trace_data}  = trace_valid ? mem_q[rd_ptr_q] : '0;
    count                              = count_q;
    overflow                           = overflow_q;
    drop_cnt                           = drop_cnt_q;
  end
endmodule

// File: tb/tb_store_trace_fifo.sv
// tb_store_trace_fifo: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the trace FIFO.
module tb_store_trace_fifo;
  logic        clk = 0, reset = 0;
  logic        memwrite = 0, clear = 0, trace_ready = 0;
  logic [31:0] pc = 0, dataadr = 0, writedata = 0, win_base = 0, win_mask = 0;
  logic        trace_valid, overflow;
  logic [31:0] trace_pc, trace_adr, trace_data;
  logic [4:0]  count;
  logic [3:0]  drop_cnt;
  int          checks = 0, errors = 0;
  bit          chk_en = 0;
  logic [95:0] q[$];
  bit          m_ovf = 0;
  int          m_drops = 0;

  store_trace_fifo #(.DEPTH(16), .DROPW(4)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .pc(pc), .dataadr(dataadr),
    .writedata(writedata), .win_base(win_base), .win_mask(win_mask), .clear(clear),
    .trace_ready(trace_ready), .trace_valid(trace_valid), .trace_pc(trace_pc),
    .trace_adr(trace_adr), .trace_data(trace_data), .count(count),
    .overflow(overflow), .drop_cnt(drop_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit qual, pop;
    qual = memwrite && ((dataadr & win_mask) == win_base);
    if (clear) begin
      q.delete();
      m_ovf = 0;
      m_drops = 0;
    end else begin
      pop = (q.size() > 0) && trace_ready;
      if (qual && (q.size() < 16 || pop)) q.push_back({pc, dataadr, writedata});
      else if (qual) begin
        m_ovf = 1;
        if (m_drops < 15) m_drops++;
      end
      if (pop) void'(q.pop_front());
    end
  endtask

  task automatic step(input logic mw, input logic [31:0] p, a, d, input logic rdy, clr);
    memwrite = mw; pc = p; dataadr = a; writedata = d; trace_ready = rdy; clear = clr;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic store(input logic [31:0] p, a, d, input logic rdy);
    step(1, p, a, d, rdy, 0);
  endtask

  task automatic idle(input logic rdy);
    step(0, 0, 0, 0, rdy, 0);
  endtask

  task automatic flush();
    step(0, 0, 0, 0, 0, 1);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", trace_valid, q.size() != 0);
      chk("count", count, q.size());
      chk("head", {trace_pc, trace_adr, trace_data}, q.size() != 0 ? q[0] : 96'h0);
      chk("overflow", overflow, m_ovf);
      chk("drop_cnt", drop_cnt, m_drops);
    end
  end

  initial begin
    logic [31:0] base, mask, a;
    logic        rdy;
    #2;
    chk("rst_valid", trace_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_data", {trace_pc, trace_adr, trace_data}, 0);
    chk("rst_ovf_drop", {overflow, drop_cnt}, 0);
    @(posedge clk); #1;
    reset = 1;
    chk_en = 1;
    store(32'h04, 32'h54, 32'h07, 0);
    chk("s1_head", {trace_valid, trace_pc, trace_adr, trace_data}, {1'b1, 32'h04, 32'h54, 32'h07});
    chk("s1_count", count, 1);
    flush();
    win_base = 32'h80; win_mask = 32'hFFFF_FFF0;
    store(32'h10, 32'h54, 32'h1, 0);
    chk("win_miss", count, 0);
    store(32'h14, 32'h84, 32'h2, 0);
    chk("win_hit", {count, trace_adr}, {5'd1, 32'h84});
    flush();
    win_base = 0; win_mask = 0;
    for (int i = 1; i <= 17; i++) store(i, i * 4, i * 3, 0);
    chk("full17", {count, overflow, drop_cnt}, {5'd16, 1'b1, 4'd1});
    for (int i = 1; i <= 16; i++) begin
      chk("drain_pc", trace_pc, i);
      idle(1);
    end
    chk("drained", {trace_valid, count}, 0);
    flush();
    for (int i = 0; i < 16; i++) store(100 + i, i, i, 0);
    store(200, 32'h200, 32'h201, 1);
    chk("full_pop_push", {count, overflow, trace_pc}, {5'd16, 1'b0, 32'd101});
    flush();
    for (int i = 0; i < 21; i++) store(i, i, i, 0);
    chk("drops5", {overflow, drop_cnt}, {1'b1, 4'd5});
    step(1, 32'h77, 32'h77, 32'h77, 0, 1);
    chk("clear_store", {count, overflow, drop_cnt, trace_valid}, 0);
    for (int i = 0; i < 40; i++) store(i, i, i, 0);
    chk("drop_sat", drop_cnt, 4'd15);
    flush();
    for (int i = 0; i < 3; i++) store(i, i, i, 0);
    #2 reset = 0;
    q.delete(); m_ovf = 0; m_drops = 0;
    #1;
    chk("mid_rst", {trace_valid, count}, 0);
    @(posedge clk); #1;
    reset = 1;
    store(32'hAB, 32'hCD, 32'hEF, 0);
    chk("post_rst", {count, trace_pc, trace_adr, trace_data}, {5'd1, 32'hAB, 32'hCD, 32'hEF});
    rdy = 0; base = 0; mask = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 256 == 0) begin
        case ($urandom_range(0, 2))
          0: begin mask = 0; base = 0; end
          1: begin mask = 32'hFFFF_FFF0; base = $urandom & mask; end
          default: begin mask = 32'hFFFF_FF00; base = $urandom & mask; end
        endcase
        win_base = base; win_mask = mask;
      end
      if (c % 32 == 0) rdy = $urandom_range(0, 3) == 0;
      a = ($urandom_range(0, 2) == 0) ? $urandom : (base | ($urandom & ~mask));
      step($urandom_range(0, 2) != 0, $urandom, a, $urandom,
           rdy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0),
           $urandom_range(0, 299) == 0);
    end
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
